// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter that owns a shared DATA_W-bit register: grants one requester at a
// time with a four-phase req/gnt handshake, loads the winner's data and counts writes.
module dff_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   d_in,
  output logic [N_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]         q_out,
  output logic                      q_valid,
  output logic                      busy,
  output logic [15:0]               wr_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_d;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [DATA_W-1:0]  wr_data;
  logic               load;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Rotating priority scan starting at ptr_q
  always_comb begin
    int         idx_i;
    logic [PTR_W-1:0] idx_p;
    win_found = 1'b0;
    win_idx   = '0;
    idx_i     = 0;
    idx_p     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_i = (int'(ptr_q) + k) % N_REQ;
      idx_p = PTR_W'(idx_i);
      if (!win_found && req[idx_p]) begin
        win_found = 1'b1;
        win_idx   = idx_p;
      end
    end
  end

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PTR_W'(i)) wr_data = d_in[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    ptr_d   = ptr_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          ptr_d   = (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + PTR_W'(1);
          load    = 1'b1;
        end
      end
      GRANT: begin
        // Other requesters stay pending; only the granted one's release matters
        if ((req & gnt) == '0) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt      <= '0;
      ptr_q    <= '0;
      busy     <= 1'b0;
      q_out    <= '0;
      q_valid  <= 1'b0;
      wr_count <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      ptr_q   <= ptr_d;
      busy    <= (state_d == GRANT);
      if (load) begin
        q_out    <= wr_data;
        q_valid  <= 1'b1;
        wr_count <= sat_inc(wr_count);
      end
    end
  end

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed bench for dff_write_arbiter: reset, single write, fairness, pointer wrap,
// hold/reset mid-grant and count saturation.
module tb_dff_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] d_in;
  logic [3:0]  gnt;
  logic [7:0]  q_out;
  logic        q_valid;
  logic        busy;
  logic [15:0] wr_count;

  int vectors = 0;
  int miscompares = 0;

  dff_write_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .d_in(d_in), .gnt(gnt),
    .q_out(q_out), .q_valid(q_valid), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dat(input int i);
    return 8'(8'hA0 + 8'h11 * i);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_q"}, 32'(q_out), 32'h0);
    check({tag, "_qv"}, 32'(q_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_cnt"}, 32'(wr_count), 32'h0);
  endtask

  initial begin
    logic [3:0] onehot;
    reset = 1'b1;
    req   = 4'hF;
    d_in  = {dat(3), dat(2), dat(1), dat(0)};

    // Reset held two cycles with all requests active
    tick(); check_reset_outputs("rst1");
    tick(); check_reset_outputs("rst2");

    reset = 1'b0;
    tick();
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_q", 32'(q_out), 32'(dat(0)));
    check("first_qv", 32'(q_valid), 32'h1);
    check("first_busy", 32'(busy), 32'h1);
    check("first_cnt", 32'(wr_count), 32'd1);

    // Fairness: each winner drops req for one cycle, then re-raises it
    for (int k = 1; k <= 5; k++) begin
      onehot = 4'b0001 << ((k - 1) % 4);
      req = 4'hF & ~onehot;
      tick();
      check($sformatf("fair%0d_rel_gnt", k), 32'(gnt), 32'h0);
      check($sformatf("fair%0d_rel_busy", k), 32'(busy), 32'h0);
      req = 4'hF;
      tick();
      check($sformatf("fair%0d_gnt", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
      check($sformatf("fair%0d_q", k), 32'(q_out), 32'(dat(k % 4)));
      check($sformatf("fair%0d_cnt", k), 32'(wr_count), 32'(k + 1));
    end

    // Pointer wrap: grant 3, then 1010 must pick 1 before 3
    req = 4'b0000; tick();
    check("wrap_idle", 32'(gnt), 32'h0);
    req = 4'b1000; tick();
    check("wrap_g3", 32'(gnt), 32'h8);
    check("wrap_g3_cnt", 32'(wr_count), 32'd7);
    req = 4'b0000; tick();
    req = 4'b1010; tick();
    check("wrap_g1", 32'(gnt), 32'h2);
    check("wrap_g1_q", 32'(q_out), 32'(dat(1)));
    check("wrap_g1_cnt", 32'(wr_count), 32'd8);
    req = 4'b1000; tick();
    check("wrap_rel", 32'(gnt), 32'h0);
    tick();
    check("wrap_g3b", 32'(gnt), 32'h8);
    check("wrap_g3b_cnt", 32'(wr_count), 32'd9);
    req = 4'b0000; tick();

    // Single requester with a distinctive data value
    d_in[23:16] = 8'hA5;
    req = 4'b0100; tick();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_q", 32'(q_out), 32'hA5);
    check("single_qv", 32'(q_valid), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    check("single_cnt", 32'(wr_count), 32'd10);
    req = 4'b0000; tick();
    check("single_rel_gnt", 32'(gnt), 32'h0);
    check("single_rel_busy", 32'(busy), 32'h0);
    tick();
    check("single_hold_q", 32'(q_out), 32'hA5);

    // Hold: requester 1 keeps req while requester 0 waits; data change must not load
    req = 4'b0010; tick();
    check("hold_gnt0", 32'(gnt), 32'h2);
    check("hold_q0", 32'(q_out), 32'(dat(1)));
    req = 4'b0011;
    d_in[15:8] = 8'h5A;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("hold%0d_gnt", c), 32'(gnt), 32'h2);
      check($sformatf("hold%0d_q", c), 32'(q_out), 32'(dat(1)));
      check($sformatf("hold%0d_cnt", c), 32'(wr_count), 32'd11);
    end

    // Reset mid-grant with requests still active
    reset = 1'b1; tick();
    check_reset_outputs("midrst");
    reset = 1'b0;
    req = 4'b1010; tick();
    check("postrst_gnt", 32'(gnt), 32'h2);
    check("postrst_q", 32'(q_out), 32'h5A);
    check("postrst_cnt", 32'(wr_count), 32'd1);
    req = 4'b0000; tick();
    check("postrst_rel", 32'(gnt), 32'h0);

    // Saturation from a preloaded count
    force dut.wr_count = 16'hFFFE;
    tick();
    release dut.wr_count;
    tick();
    check("sat_pre", 32'(wr_count), 32'hFFFE);
    for (int s = 0; s < 3; s++) begin
      req = 4'b0001; tick();
      check($sformatf("sat%0d_gnt", s), 32'(gnt), 32'h1);
      check($sformatf("sat%0d_cnt", s), 32'(wr_count), 32'hFFFF);
      req = 4'b0000; tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
